// File: rtl/fifo_burst_pkg.sv
// Shared types for the burst-drain stage that sits behind the event/fault-record FIFO.
package fifo_burst_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DRAIN     = 2'd1,
      WAIT_LAST = 2'd2
   } state_e;

   // Shadow occupancy must represent every value from 0 up to depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_burst_drain.sv
// Coalesces queued FIFO records into bursts (almost-full or timeout trigger) and drains them
// over a valid/ready stream, marking the final beat of each burst with last_o.
module fifo_burst_drain
   import fifo_burst_pkg::*;
#(
   parameter int  DATA_WIDTH = 32,
   parameter type dtype      = logic [DATA_WIDTH-1:0],
   parameter int  DEPTH      = 8,
   parameter int  MAX_BURST  = 4,
   parameter int  TIMEOUT    = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush_i,
   input  logic fifo_push_i,
   input  logic fifo_full_i,
   input  logic fifo_empty_i,
   input  logic fifo_alm_full_i,
   input  dtype fifo_data_i,
   output logic fifo_pop_o,
   output logic valid_o,
   input  logic ready_i,
   output dtype data_o,
   output logic last_o,
   output logic busy_o
);

   localparam int OCC_W = occ_width(DEPTH);
   localparam int TMR_W = $clog2(TIMEOUT) + 1;
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] CNT_LAST = OCC_W'(MAX_BURST - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   state_e           r_state,    w_state_nxt;
   logic [TMR_W-1:0] r_timer,    w_timer_nxt;
   logic [OCC_W-1:0] r_beat_cnt, w_beat_nxt;
   logic [OCC_W-1:0] r_occ,      w_occ_nxt;
   dtype             r_data,     w_data_nxt;
   logic             r_valid,    w_valid_nxt;
   logic             r_last,     w_last_nxt;
   logic             w_pop;
   logic             w_push_acc;
   logic             w_hs;
   logic             w_last_cap;

   assign w_push_acc = fifo_push_i & ~fifo_full_i;
   assign w_hs       = r_valid & ready_i;
   // The popped beat closes the burst if it fills MAX_BURST or leaves the FIFO empty.
   assign w_last_cap = (r_beat_cnt == CNT_LAST) | ((r_occ == OCC_ONE) & ~w_push_acc);

   // State, counters and output register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_timer    <= '0;
         r_beat_cnt <= '0;
         r_occ      <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_timer    <= w_timer_nxt;
         r_beat_cnt <= w_beat_nxt;
         r_occ      <= w_occ_nxt;
         r_data     <= w_data_nxt;
         r_valid    <= w_valid_nxt;
         r_last     <= w_last_nxt;
      end
   end

   // Next-state, pop request and output-register update.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_beat_nxt  = r_beat_cnt;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_last_nxt  = r_last;
      w_pop       = 1'b0;

      if (w_hs) begin
         w_valid_nxt = 1'b0;
         w_last_nxt  = 1'b0;
         w_data_nxt  = '0;
      end else begin
         w_valid_nxt = r_valid;
      end

      if (flush_i) begin
         w_state_nxt = IDLE;
         w_timer_nxt = '0;
         w_beat_nxt  = '0;
         w_valid_nxt = 1'b0;
         w_last_nxt  = 1'b0;
         w_data_nxt  = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (fifo_empty_i) begin
                  w_timer_nxt = '0;
               end else if (fifo_alm_full_i | (r_timer == TMR_LAST)) begin
                  w_state_nxt = DRAIN;
                  w_timer_nxt = '0;
                  w_beat_nxt  = '0;
               end else begin
                  w_timer_nxt = r_timer + TMR_ONE;
               end
            end
            DRAIN: begin
               w_pop = ~fifo_empty_i & (~r_valid | ready_i);
               if (w_pop) begin
                  w_data_nxt  = fifo_data_i;
                  w_valid_nxt = 1'b1;
                  w_last_nxt  = w_last_cap;
                  w_beat_nxt  = r_beat_cnt + OCC_ONE;
                  if (w_last_cap) begin
                     w_state_nxt = WAIT_LAST;
                  end else begin
                     w_state_nxt = DRAIN;
                  end
               end else if (fifo_empty_i & ~r_valid) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DRAIN;
               end
            end
            WAIT_LAST: begin
               if (w_hs & r_last) begin
                  w_state_nxt = IDLE;
                  w_timer_nxt = '0;
               end else begin
                  w_state_nxt = WAIT_LAST;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // Shadow occupancy of the upstream FIFO, saturating at both ends.
   always_comb begin
      w_occ_nxt = r_occ;
      if (flush_i) begin
         w_occ_nxt = '0;
      end else if (w_push_acc & ~w_pop & (r_occ != OCC_FULL)) begin
         w_occ_nxt = r_occ + OCC_ONE;
      end else if (~w_push_acc & w_pop & (r_occ != '0)) begin
         w_occ_nxt = r_occ - OCC_ONE;
      end else begin
         w_occ_nxt = r_occ;
      end
   end

   assign fifo_pop_o = w_pop;
   assign valid_o    = r_valid;
   assign data_o     = r_data;
   assign last_o     = r_last;
   assign busy_o     = (r_state != IDLE) | r_valid;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: behavioural FIFO model, stream log with expected beats derived
// from the burst rules, directed scenario tasks and a randomized traffic run.
module tb_fifo_burst_drain;

   localparam int DW        = 32;
   localparam int DEPTH     = 8;
   localparam int MAX_BURST = 4;
   localparam int TIMEOUT   = 16;
   localparam int ALM_TH    = 6;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b1;
   logic          flush      = 1'b0;
   logic          push       = 1'b0;
   logic [DW-1:0] push_data  = '0;
   logic          ready      = 1'b0;
   logic          fifo_full  = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          fifo_alm   = 1'b0;
   logic [DW-1:0] fifo_head  = '0;
   logic          pop, valid, last, busy;
   logic [DW-1:0] data;
   logic          push_acc_m;

   int n_pass = 0;
   int n_total = 0;
   int hold_err = 0;
   int pop_empty_err = 0;
   int burst_pos = 0;
   int acc_total = 0;
   logic          prev_hold = 1'b0;
   logic          hold_last = 1'b0;
   logic [DW-1:0] hold_data = '0;
   logic [DW-1:0] mq[$];
   logic [DW:0]   pend_q[$];
   logic [DW:0]   got_q[$];
   logic [DW:0]   exp_q[$];

   always #5 clk = ~clk;

   fifo_burst_drain #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .fifo_push_i(push),
      .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty), .fifo_alm_full_i(fifo_alm),
      .fifo_data_i(fifo_head), .fifo_pop_o(pop), .valid_o(valid), .ready_i(ready),
      .data_o(data), .last_o(last), .busy_o(busy)
   );

   assign push_acc_m = push && !fifo_full;

   // Upstream FIFO model; flags change only at the clock edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         mq.delete();
      end else begin
         if (pop && !fifo_empty) void'(mq.pop_front());
         if (push_acc_m) begin
            mq.push_back(push_data);
            acc_total <= acc_total + 1;
         end
      end
      fifo_empty <= (mq.size() == 0);
      fifo_full  <= (mq.size() == DEPTH);
      fifo_alm   <= (mq.size() >= ALM_TH);
      fifo_head  <= (mq.size() > 0) ? mq[0] : '0;
   end

   // A popped record ends its burst when it is the MAX_BURST-th beat or the FIFO is left empty.
   function automatic bit exp_last_f();
      return (burst_pos == MAX_BURST - 1) || (mq.size() == 1 && !push_acc_m);
   endfunction

   // Stream monitor: logs delivered beats next to the beat the rules predict.
   always @(negedge clk) begin
      if (!rst_n || flush) begin
         pend_q.delete();
         burst_pos <= 0;
         prev_hold <= 1'b0;
      end else begin
         if (prev_hold && (!valid || data !== hold_data || last !== hold_last))
            hold_err <= hold_err + 1;
         prev_hold <= valid && !ready;
         hold_data <= data;
         hold_last <= last;
         if (valid && ready) begin
            got_q.push_back({last, data});
            if (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
            else exp_q.push_back({~last, ~data});
         end
         if (pop) begin
            if (mq.size() == 0) begin
               pop_empty_err <= pop_empty_err + 1;
            end else begin
               pend_q.push_back({exp_last_f(), mq[0]});
               burst_pos <= exp_last_f() ? 0 : burst_pos + 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      n_total++;
      if ({valid, last, pop, busy} !== 4'b0000)
         $display("FAIL reset_ctrl: got v/l/p/b=%b expected 0000", {valid, last, pop, busy});
      else n_pass++;
      n_total++;
      if (data !== '0) $display("FAIL reset_data: got %h expected 0", data);
      else n_pass++;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      ready = 1'b1;
   endtask

   task automatic test_timeout();
      logic [DW-1:0] d;
      int early;
      d = $urandom;
      early = 0;
      push = 1'b1; push_data = d;
      tick();
      push = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clk);
         if (pop) early++;
         tick();
      end
      n_total++;
      if (early !== 0) $display("FAIL timeout_early: got %0d early pops expected 0", early);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (pop !== 1'b1) $display("FAIL timeout_pop: got %b expected 1", pop);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if ({valid, last, data} !== {2'b11, d})
         $display("FAIL timeout_beat: got v/l/d=%b%b %h expected 11 %h", valid, last, data, d);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if ({busy, valid} !== 2'b00) $display("FAIL timeout_idle: got b/v=%b expected 00", {busy, valid});
      else n_pass++;
      tick();
   endtask

   task automatic test_alm_burst();
      logic [DW-1:0] d[6];
      bit            lp[6];
      int            base, n;
      lp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      base = got_q.size();
      for (int i = 0; i < 6; i++) begin
         d[i] = $urandom;
         push = 1'b1; push_data = d[i];
         tick();
      end
      push = 1'b0;
      n = 0;
      while (got_q.size() < base + 6 && n < 80) begin
         tick();
         n++;
      end
      n_total++;
      if (got_q.size() - base !== 6) $display("FAIL alm_count: got %0d beats expected 6", got_q.size() - base);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_total++;
         if (got_q.size() <= base + i || got_q[base+i] !== {lp[i], d[i]})
            $display("FAIL alm_beat%0d: got %h expected %h", i,
                     (got_q.size() > base + i) ? got_q[base+i] : '0, {lp[i], d[i]});
         else n_pass++;
      end
      tick();
   endtask

   task automatic test_stall();
      logic [DW-1:0] d[3];
      int            base, hs, n;
      base = got_q.size();
      hs = 0;
      for (int i = 0; i < 3; i++) begin
         d[i] = $urandom;
         push = 1'b1; push_data = d[i];
         tick();
      end
      push = 1'b0;
      n = 0;
      while (hs < 1 && n < 40) begin
         @(negedge clk);
         if (valid && ready) hs++;
         tick();
         n++;
      end
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_total++;
         if ({valid, last, pop, data} !== {3'b100, d[1]})
            $display("FAIL stall_hold%0d: got v/l/p=%b%b%b %h expected 100 %h", i, valid, last, pop, data, d[1]);
         else n_pass++;
         tick();
      end
      ready = 1'b1;
      n = 0;
      while (got_q.size() < base + 3 && n < 20) begin
         tick();
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (got_q.size() <= base + i || got_q[base+i] !== {(i == 2), d[i]})
            $display("FAIL stall_order%0d: got %h expected %h", i,
                     (got_q.size() > base + i) ? got_q[base+i] : '0, {(i == 2), d[i]});
         else n_pass++;
      end
      tick();
      tick();
   endtask

   task automatic test_occ_push();
      logic [DW-1:0] d0, d1;
      d0 = $urandom;
      d1 = $urandom;
      push = 1'b1; push_data = d0;
      tick();
      push = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) tick();
      push = 1'b1; push_data = d1;
      @(negedge clk);
      n_total++;
      if (pop !== 1'b1) $display("FAIL occpush_pop: got %b expected 1", pop);
      else n_pass++;
      tick();
      push = 1'b0;
      @(negedge clk);
      n_total++;
      if ({valid, last, data} !== {2'b10, d0})
         $display("FAIL occpush_beat1: got v/l=%b%b %h expected 10 %h", valid, last, data, d0);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if ({valid, last, data} !== {2'b11, d1})
         $display("FAIL occpush_beat2: got v/l=%b%b %h expected 11 %h", valid, last, data, d1);
      else n_pass++;
      tick();
      tick();
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0) $display("FAIL occpush_idle: got busy=%b expected 0", busy);
      else n_pass++;
      tick();
   endtask

   task automatic test_flush();
      logic [DW-1:0] d;
      int            base, n, early;
      bit            seen;
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push = 1'b1; push_data = $urandom;
         tick();
      end
      push = 1'b0;
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         seen = pop;
         tick();
         n++;
      end
      base = got_q.size();
      ready = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      n_total++;
      if ({valid, pop} !== 2'b10) $display("FAIL flush_pop: got v/p=%b%b expected 10", valid, pop);
      else n_pass++;
      tick();
      flush = 1'b0;
      @(negedge clk);
      n_total++;
      if ({valid, busy, last} !== 3'b000) $display("FAIL flush_clear: got v/b/l=%b expected 000", {valid, busy, last});
      else n_pass++;
      n_total++;
      if (got_q.size() !== base) $display("FAIL flush_drop: got %0d beats expected 0", got_q.size() - base);
      else n_pass++;
      tick();
      d = $urandom;
      early = 0;
      push = 1'b1; push_data = d;
      tick();
      push = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clk);
         if (pop) early++;
         tick();
      end
      @(negedge clk);
      n_total++;
      if ({early == 0, pop} !== 2'b11) $display("FAIL flush_fresh_timeout: got early=%0d pop=%b expected 0 1", early, pop);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if ({valid, last, data} !== {2'b11, d})
         $display("FAIL flush_fresh_beat: got v/l=%b%b %h expected 11 %h", valid, last, data, d);
      else n_pass++;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      int n;
      bit seen;
      ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         push = 1'b1; push_data = $urandom | 32'h1;
         tick();
      end
      push = 1'b0;
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         seen = pop;
         tick();
         n++;
      end
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({valid, last, pop, busy} !== 4'b0000)
         $display("FAIL rstmid_ctrl: got v/l/p/b=%b expected 0000", {valid, last, pop, busy});
      else n_pass++;
      n_total++;
      if (data !== '0) $display("FAIL rstmid_data: got %h expected 0", data);
      else n_pass++;
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      ready = 1'b1;
      tick();
   endtask

   task automatic test_random();
      int base, acc0, n, run, maxrun;
      base = got_q.size();
      acc0 = acc_total;
      for (int i = 0; i < 600; i++) begin
         push      = ($urandom_range(0, 99) < 45);
         push_data = $urandom;
         ready     = ($urandom_range(0, 99) < 70);
         tick();
      end
      push = 1'b0;
      ready = 1'b1;
      n = 0;
      while (!(fifo_empty && !busy) && n < 300) begin
         tick();
         n++;
      end
      n_total++;
      if (busy !== 1'b0 || fifo_empty !== 1'b1)
         $display("FAIL rand_drain: got busy=%b empty=%b expected 0 1", busy, fifo_empty);
      else n_pass++;
      n_total++;
      if (got_q.size() - base !== acc_total - acc0)
         $display("FAIL rand_count: got %0d beats expected %0d", got_q.size() - base, acc_total - acc0);
      else n_pass++;
      run = 0; maxrun = 0;
      for (int i = base; i < got_q.size(); i++) begin
         n_total++;
         if (i >= exp_q.size() || got_q[i] !== exp_q[i])
            $display("FAIL rand_beat%0d: got %h expected %h", i - base, got_q[i],
                     (i < exp_q.size()) ? exp_q[i] : '0);
         else n_pass++;
         run++;
         if (got_q[i][DW]) begin
            if (run > maxrun) maxrun = run;
            run = 0;
         end
      end
      n_total++;
      if (maxrun > MAX_BURST || run != 0)
         $display("FAIL rand_burstlen: got max %0d open %0d expected <=%0d and 0", maxrun, run, MAX_BURST);
      else n_pass++;
      n_total++;
      if ({hold_err, pop_empty_err} !== 64'd0)
         $display("FAIL rand_protocol: got hold_err=%0d pop_empty=%0d expected 0 0", hold_err, pop_empty_err);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_alm_burst();
      test_stall();
      test_occ_push();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before 500000");
      $fatal(1);
   end

endmodule
